// File: rtl/fp_class_pkg.sv
// Shared definitions for the FCLASS pipeline and its decode helper.
// Class bit indices follow the RISC-V FCLASS result layout.
package fp_class_pkg;

    localparam int CLASS_W  = 10;

    localparam int CLS_NINF = 0;
    localparam int CLS_NNRM = 1;
    localparam int CLS_NSUB = 2;
    localparam int CLS_NZER = 3;
    localparam int CLS_PZER = 4;
    localparam int CLS_PSUB = 5;
    localparam int CLS_PNRM = 6;
    localparam int CLS_PINF = 7;
    localparam int CLS_SNAN = 8;
    localparam int CLS_QNAN = 9;

    typedef logic [CLASS_W-1:0] fp_class_t;

    // Reduced operand fields carried from the first stage to the decoder
    typedef struct packed {
        logic sign;
        logic e1;
        logic e0;
        logic m0;
        logic q;
    } fp_flags_t;

    function automatic logic is_nan(input fp_class_t c);
        return c[CLS_SNAN] | c[CLS_QNAN];
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational FCLASS decode from reduced fields to a one-hot class.
// Shared with the FP compare unit.
module fp_class_decode
    import fp_class_pkg::*;
(
    input  fp_flags_t flags_i,
    output fp_class_t class_o
);

    logic s;
    logic e1;
    logic e0;
    logic m0;
    logic q;

    assign s  = flags_i.sign;
    assign e1 = flags_i.e1;
    assign e0 = flags_i.e0;
    assign m0 = flags_i.m0;
    assign q  = flags_i.q;

    // Arms are mutually exclusive; NaN arms ignore the sign
    always_comb begin
        class_o = '0;
        unique case (1'b1)
            e1 & m0: begin
                class_o[CLS_NINF] = s;
                class_o[CLS_PINF] = ~s;
            end
            e1 & ~m0 & q: begin
                class_o[CLS_QNAN] = 1'b1;
            end
            e1 & ~m0 & ~q: begin
                class_o[CLS_SNAN] = 1'b1;
            end
            ~e1 & e0 & m0: begin
                class_o[CLS_NZER] = s;
                class_o[CLS_PZER] = ~s;
            end
            ~e1 & e0 & ~m0: begin
                class_o[CLS_NSUB] = s;
                class_o[CLS_PSUB] = ~s;
            end
            default: begin
                class_o[CLS_NNRM] = s;
                class_o[CLS_PNRM] = ~s;
            end
        endcase
    end

endmodule

// File: rtl/fp_class_pipe.sv
// Two-stage elastic FCLASS pipeline with sticky class OR and NaN counter.
// Sits between FP regfile read and the integer writeback arbiter.
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8,
    localparam int FW   = 1 + EXP_W + MAN_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FW-1:0]     in_f,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_class,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              sticky_clr,
    output logic [CLASS_W-1:0] sticky_class,
    output logic [CNT_W-1:0]  nan_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [EXP_W-1:0] exp_w;
    logic [MAN_W-1:0] man_w;
    fp_flags_t        in_flags;

    assign exp_w = in_f[FW-2 -: EXP_W];
    assign man_w = in_f[MAN_W-1:0];

    assign in_flags.sign = in_f[FW-1];
    assign in_flags.e1   = &exp_w;
    assign in_flags.e0   = ~|exp_w;
    assign in_flags.m0   = ~|man_w;
    assign in_flags.q    = man_w[MAN_W-1];

    logic             s1_valid_q, s1_valid_d;
    fp_flags_t        s1_flags_q, s1_flags_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    fp_class_t        s2_class_q, s2_class_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    fp_class_t        sticky_q,   sticky_d;
    logic [CNT_W-1:0] nan_q,      nan_d;

    logic      s2_load;
    logic      s1_moves;
    logic      s1_load;
    logic      accept;
    logic      hs;
    fp_class_t s1_class;

    fp_class_decode u_dec (
        .flags_i (s1_flags_q),
        .class_o (s1_class)
    );

    // Ready ripples back combinationally so a streaming pipe never bubbles
    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_moves = s1_valid_q & s2_load;
    assign s1_load  = ~s1_valid_q | s1_moves;
    assign in_ready = RST & EN & s1_load;
    assign accept   = in_valid & in_ready;
    assign hs       = s2_valid_q & out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_flags_d = s1_flags_q;
        s1_tag_d   = s1_tag_q;
        if (s1_load) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_flags_d = in_flags;
            s1_tag_d   = in_tag;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_class_d = s2_class_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_moves) begin
            s2_class_d = s1_class;
            s2_tag_d   = s1_tag_q;
        end
    end

    // A clear coinciding with a handoff keeps that handoff's contribution
    always_comb begin
        sticky_d = sticky_q;
        nan_d    = nan_q;
        if (sticky_clr) begin
            sticky_d = hs ? s2_class_q : '0;
            nan_d    = (hs && is_nan(s2_class_q)) ? CNT_W'(1) : '0;
        end else if (hs) begin
            sticky_d = sticky_q | s2_class_q;
            if (is_nan(s2_class_q) && (nan_q != CNT_MAX)) begin
                nan_d = nan_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_flags_q <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_class_q <= '0;
            s2_tag_q   <= '0;
            sticky_q   <= '0;
            nan_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_flags_q <= s1_flags_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_class_q <= s2_class_d;
            s2_tag_q   <= s2_tag_d;
            sticky_q   <= sticky_d;
            nan_q      <= nan_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_class    = XLEN'(s2_class_q);
    assign out_tag      = s2_tag_q;
    assign sticky_class = sticky_q;
    assign nan_cnt      = nan_q;

endmodule
